// File: rtl/aes_pkg.sv
// aes_pkg -- shared AES-128 key-schedule definitions.
//   AES_NR      : number of AES-128 rounds (10; no other value is supported)
//   ks_state_e  : 2-bit state encoding of the key-schedule controller
//   rcon()      : round constant for a round number; 8'h00 outside 1..AES_NR
//   rnd_valid() : true when a round number lies in 1..AES_NR
package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } ks_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic rnd_valid(input logic [3:0] rnd);
    return (rnd >= 4'd1) && (rnd <= 4'(AES_NR));
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox -- combinational AES forward S-box, shared by SubWord and SubBytes.
//   din  : input byte
//   dout : substituted byte
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Index 0 is the leftmost byte of the first row.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/key_schedule.sv
// key_schedule -- on-the-fly AES-128 key expansion, one round key per en.
//   clk       : clock, all state updates on the rising edge
//   arst      : synchronous active-low reset
//   start     : load key_in as round key 0 (accepted in any state, beats en)
//   key_in    : cipher key, byte 0 in [127:120]
//   en        : advance one round (only while ACTIVE)
//   round     : round number from the external round counter, 1..NR
//   round_key : current round key (registered)
//   busy      : schedule in progress (ACTIVE)
//   last      : round_key holds the final round key (DONE)
//   rnd_err   : sticky flag, round disagreed with the internal index
module key_schedule
  import aes_pkg::*;
#(
  parameter int NR = AES_NR  // only 10 is supported
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         en,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         last,
  output logic         rnd_err
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  ks_state_e    state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic         err_q, err_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3, sub_w3, temp_w;
  logic [31:0]  n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .din  (rot_w3[8*i +: 8]),
      .dout (sub_w3[8*i +: 8])
    );
  end

  // The key always advances with the supplied round, even when it is flagged.
  assign temp_w = sub_w3 ^ {rcon(round), 24'h000000};
  assign n0 = w0 ^ temp_w;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_comb begin
    // NOTE: every _d takes its _q value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    err_d   = err_q;
    if (start) begin
      state_d = ST_ACTIVE;
      key_d   = key_in;
      idx_d   = 4'd0;
      err_d   = 1'b0;
    end else if (state_q == ST_ACTIVE && en) begin
      key_d = {n0, n1, n2, n3};
      idx_d = idx_q + 4'd1;
      if (round != idx_q + 4'd1 || !rnd_valid(round)) begin
        err_d = 1'b1;
      end
      if (idx_q + 4'd1 == LAST_IDX) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the key register is cleared on reset too, so no partial key
    // survives; non-blocking assignments keep every flop sampling old values.
    if (!arst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign round_key = key_q;
  assign busy      = (state_q == ST_ACTIVE);
  assign last      = (state_q == ST_DONE);
  assign rnd_err   = err_q;

endmodule

// File: tb/tb_key_schedule.sv
// tb_key_schedule -- directed bench for key_schedule with FIPS-197 vectors
// and hand-computed round keys for boundary rounds.
module tb_key_schedule;

  logic         clk = 1'b0;
  logic         arst;
  logic         start;
  logic [127:0] key_in;
  logic         en;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         busy;
  logic         last;
  logic         rnd_err;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_R3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] ZERO_RC4 = 128'h67636363676363636763636367636363;
  localparam logic [127:0] ZERO_RC0 = 128'h63636363636363636363636363636363;
  localparam logic [127:0] ZERO_RC36 = 128'h55636363556363635563636355636363;

  always #5 clk = ~clk;

  key_schedule #(.NR(10)) dut (
    .clk       (clk),
    .arst      (arst),
    .start     (start),
    .key_in    (key_in),
    .en        (en),
    .round     (round),
    .round_key (round_key),
    .busy      (busy),
    .last      (last),
    .rnd_err   (rnd_err)
  );

  // Outputs are sampled 1 ns after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    tick();
    start  = 1'b0;
  endtask

  task automatic drive_en(input logic [3:0] r);
    en    = 1'b1;
    round = r;
    tick();
    en    = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b0; start = 1'b0; en = 1'b0; round = 4'd0; key_in = '0;
    tick(); tick();
    n_total++; if (round_key !== 128'h0) $display("FAIL reset_key: got %h want 0", round_key); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (last !== 1'b0) $display("FAIL reset_last: got %b want 0", last); else n_pass++;
    n_total++; if (rnd_err !== 1'b0) $display("FAIL reset_err: got %b want 0", rnd_err); else n_pass++;
    arst = 1'b1;
    tick();
    drive_en(4'd1);
    n_total++; if (round_key !== 128'h0) $display("FAIL idle_en_key: got %h want 0", round_key); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL idle_en_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_fips_schedule();
    drive_start(FIPS_KEY);
    n_total++; if (round_key !== FIPS_KEY) $display("FAIL fips_load: got %h want %h", round_key, FIPS_KEY); else n_pass++;
    n_total++; if (busy !== 1'b1 || last !== 1'b0) $display("FAIL fips_load_flags: got busy=%b last=%b want 1 0", busy, last); else n_pass++;
    drive_en(4'd1);
    n_total++; if (round_key !== FIPS_R1) $display("FAIL fips_r1: got %h want %h", round_key, FIPS_R1); else n_pass++;
    drive_en(4'd2);
    n_total++; if (round_key !== FIPS_R2) $display("FAIL fips_r2: got %h want %h", round_key, FIPS_R2); else n_pass++;
    drive_en(4'd3);
    n_total++; if (round_key !== FIPS_R3) $display("FAIL fips_r3: got %h want %h", round_key, FIPS_R3); else n_pass++;
    for (int r = 4; r <= 9; r++) drive_en(4'(r));
    n_total++; if (busy !== 1'b1 || last !== 1'b0) $display("FAIL fips_r9_flags: got busy=%b last=%b want 1 0", busy, last); else n_pass++;
    drive_en(4'd10);
    n_total++; if (round_key !== FIPS_R10) $display("FAIL fips_r10: got %h want %h", round_key, FIPS_R10); else n_pass++;
    n_total++; if (last !== 1'b1 || busy !== 1'b0) $display("FAIL fips_done_flags: got last=%b busy=%b want 1 0", last, busy); else n_pass++;
    n_total++; if (rnd_err !== 1'b0) $display("FAIL fips_err: got %b want 0", rnd_err); else n_pass++;
  endtask

  task automatic test_done_hold();
    drive_en(4'd1);
    drive_en(4'd5);
    drive_en(4'd11);
    n_total++; if (round_key !== FIPS_R10) $display("FAIL done_hold_key: got %h want %h", round_key, FIPS_R10); else n_pass++;
    n_total++; if (last !== 1'b1 || rnd_err !== 1'b0) $display("FAIL done_hold_flags: got last=%b err=%b want 1 0", last, rnd_err); else n_pass++;
    drive_start(128'h0);
    n_total++; if (busy !== 1'b1 || last !== 1'b0) $display("FAIL done_restart_flags: got busy=%b last=%b want 1 0", busy, last); else n_pass++;
    n_total++; if (round_key !== 128'h0) $display("FAIL done_restart_key: got %h want 0", round_key); else n_pass++;
  endtask

  task automatic test_zero_key();
    drive_en(4'd1);
    n_total++; if (round_key !== ZERO_R1) $display("FAIL zero_r1: got %h want %h", round_key, ZERO_R1); else n_pass++;
    en = 1'b0; round = 4'd2;
    tick(); tick(); tick();
    n_total++; if (round_key !== ZERO_R1) $display("FAIL en_low_hold: got %h want %h", round_key, ZERO_R1); else n_pass++;
    drive_en(4'd2);
    n_total++; if (round_key !== ZERO_R2) $display("FAIL zero_r2: got %h want %h", round_key, ZERO_R2); else n_pass++;
    n_total++; if (rnd_err !== 1'b0) $display("FAIL zero_err: got %b want 0", rnd_err); else n_pass++;
  endtask

  task automatic test_round_error();
    drive_start(128'h0);
    drive_en(4'd3);
    n_total++; if (round_key !== ZERO_RC4) $display("FAIL err_rc4_key: got %h want %h", round_key, ZERO_RC4); else n_pass++;
    n_total++; if (rnd_err !== 1'b1) $display("FAIL err_set: got %b want 1", rnd_err); else n_pass++;
    drive_en(4'd2);
    n_total++; if (rnd_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", rnd_err); else n_pass++;
    drive_start(128'h0);
    n_total++; if (rnd_err !== 1'b0) $display("FAIL err_clear: got %b want 0", rnd_err); else n_pass++;
    drive_en(4'd0);
    n_total++; if (round_key !== ZERO_RC0 || rnd_err !== 1'b1) $display("FAIL err_round0: got %h err=%b want %h err=1", round_key, rnd_err, ZERO_RC0); else n_pass++;
    drive_start(128'h0);
    drive_en(4'd10);
    n_total++; if (round_key !== ZERO_RC36 || rnd_err !== 1'b1) $display("FAIL err_round10_first: got %h err=%b want %h err=1", round_key, rnd_err, ZERO_RC36); else n_pass++;
    n_total++; if (busy !== 1'b1 || last !== 1'b0) $display("FAIL err_round10_flags: got busy=%b last=%b want 1 0", busy, last); else n_pass++;
    drive_start(128'h0);
    drive_en(4'd11);
    n_total++; if (round_key !== ZERO_RC0 || rnd_err !== 1'b1) $display("FAIL err_round11: got %h err=%b want %h err=1", round_key, rnd_err, ZERO_RC0); else n_pass++;
  endtask

  task automatic test_start_wins();
    drive_start(FIPS_KEY);
    drive_en(4'd1);
    drive_en(4'd2);
    start = 1'b1; en = 1'b1; round = 4'd3; key_in = 128'h0;
    tick();
    start = 1'b0; en = 1'b0;
    n_total++; if (round_key !== 128'h0 || busy !== 1'b1) $display("FAIL start_wins_key: got %h busy=%b want 0 busy=1", round_key, busy); else n_pass++;
    drive_en(4'd1);
    n_total++; if (round_key !== ZERO_R1 || rnd_err !== 1'b0) $display("FAIL start_wins_idx: got %h err=%b want %h err=0", round_key, rnd_err, ZERO_R1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive_start(FIPS_KEY);
    for (int r = 1; r <= 5; r++) drive_en(4'(r));
    n_total++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy); else n_pass++;
    arst = 1'b0; en = 1'b1; round = 4'd6;
    tick();
    arst = 1'b1; en = 1'b0;
    n_total++; if (round_key !== 128'h0 || busy !== 1'b0 || last !== 1'b0) $display("FAIL mid_reset: got %h busy=%b last=%b want 0 0 0", round_key, busy, last); else n_pass++;
    drive_en(4'd1);
    n_total++; if (round_key !== 128'h0 || busy !== 1'b0) $display("FAIL mid_idle_en: got %h busy=%b want 0 0", round_key, busy); else n_pass++;
    drive_start(128'h0);
    drive_en(4'd7);
    arst = 1'b0; start = 1'b1; key_in = FIPS_KEY;
    tick();
    arst = 1'b1; start = 1'b0;
    n_total++; if (rnd_err !== 1'b0 || round_key !== 128'h0 || busy !== 1'b0) $display("FAIL reset_over_start: got %h err=%b busy=%b want 0 0 0", round_key, rnd_err, busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fips_schedule();
    test_done_hold();
    test_zero_key();
    test_round_error();
    test_start_wins();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 Parameter NR, default 10, number of AES-128 rounds; only 10 SHALL be supported.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 arst  in  1  reset; synchronous, active-low.
REQ-004 start  in  1  one-cycle pulse; load key_in as round key 0.
REQ-005 key_in  in  128  cipher key, byte 0 in bits [127:120].
REQ-006 en  in  1  advance one round; the same strobe that steps the round counter.
REQ-007 round  in  4  current round number from the round counter, 1..10.
REQ-008 round_key  out  128  current round key, registered.
REQ-009 busy  out  1  high in ACTIVE.
REQ-010 last  out  1  high while round_key holds round key 10.
REQ-011 rnd_err  out  1  sticky; round input disagreed with the internal round index.

Function
REQ-012 States SHALL be IDLE, ACTIVE and DONE, encoded in 2 bits.
REQ-013 In IDLE, start SHALL load round_key<=key_in, idx<=0 and go to ACTIVE; en SHALL be ignored.
REQ-014 In ACTIVE, each en SHALL compute the next key from round_key with Rcon(round) and register it, with one-cycle latency; idx<=idx+1.
REQ-015 The next-key computation SHALL be: t=SubWord(RotWord(w3)) xor {Rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-016 Rcon SHALL be 01,02,04,08,10,20,40,80,1B,36 for round 1..10; round 0 or 11..15 SHALL give Rcon 00 and set rnd_err.
REQ-017 On every accepted en, rnd_err SHALL set if round != idx+1; the key SHALL still advance using the round input.
REQ-018 The en that makes idx reach 10 SHALL move the block to DONE; last SHALL be high in DONE only.
REQ-019 In DONE, en SHALL be ignored and round_key SHALL hold.
REQ-020 start SHALL be accepted in any state; it restarts from key_in and clears rnd_err.
REQ-021 If start and en arrive in the same cycle, start SHALL win and en SHALL be dropped.
REQ-022 With en low, round_key and idx SHALL hold.

Reset
REQ-023 arst low at a clk edge SHALL force IDLE, round_key=0, idx=0, busy=0, last=0 and rnd_err=0.
REQ-024 Reset SHALL override start and en, including mid-schedule; no partial key SHALL survive it.

Structure
REQ-025 The state encoding, the Rcon table and NR SHALL live in a shared package, aes_pkg.
REQ-026 A combinational sub-module aes_sbox (8-bit in, 8-bit out) SHALL be instantiated 4 times for SubWord; it is reusable by the SubBytes stage.
REQ-027 No other sub-modules SHALL exist, and no multicycle paths SHALL be used.

Verification
REQ-028 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start, then en with round=1 -> next cycle round_key=a0fafe1788542cb123a339392a6c7605.
REQ-029 Same key, 10 en with round 1..10 -> round_key=d014f9a8c9ee2589e13f0cc8b6630ca6, last=1, busy=0, rnd_err=0.
REQ-030 All-zero key, one en with round=1 -> round_key=62636363626363636263636362636363.
REQ-031 In DONE, pulse en 3 times -> round_key unchanged; then start with a new key -> ACTIVE and rnd_err=0.
REQ-032 After start, en with round=3 -> rnd_err=1 and Rcon=04 used; start and en in the same cycle -> round_key=key_in and idx=0.
REQ-033 Drive arst low after the 5th en -> next edge gives IDLE, round_key=0, last=0; en with arst high in IDLE -> no change.
